blue_seq_alu: RTL and testbench

BLUE_SEQ_ALU -- requirements
Module: blue_seq_alu

---
 rtl/blue_pkg.sv | 28 ++
 rtl/blue_seq_alu_if.sv | 27 ++
 rtl/blue_mul_iter.sv | 50 +++++
 rtl/blue_seq_alu.sv | 133 +++++++++++++
 tb/tb_blue_seq_alu.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/blue_pkg.sv
// Shared types for the blue sequential ALU: opcodes, FSM states and flag bit positions.
package blue_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_MUL = 4'd8,
    OP_CMP = 4'd9,
    OP_NOP = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int Z_BIT = 2;
  localparam int N_BIT = 1;
  localparam int C_BIT = 0;

endpackage

// File: rtl/blue_seq_alu_if.sv
// Command/result handshake bundle between a requester (master) and the ALU (slave).
interface blue_seq_alu_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [2:0]       znc_out;
  logic             busy;

  modport master (
    output in_valid, op, a_in, b_in, out_ready,
    input  in_ready, out_valid, a_out, b_out, znc_out, busy
  );

  modport slave (
    input  in_valid, op, a_in, b_in, out_ready,
    output in_ready, out_valid, a_out, b_out, znc_out, busy
  );
endinterface

// File: rtl/blue_mul_iter.sv
// Unsigned shift-add multiplier, one partial product per clock; done is asserted
// combinationally during the final iteration so product can be taken on that edge.
module blue_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic               running;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     partial;

  // acc holds {high sum, remaining multiplier bits}; each step adds then shifts right
  always_comb begin
    partial = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
  end

  assign product = {partial, acc[WIDTH-1:1]};
  assign done    = running && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      acc     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      mcand   <= a_in;
      acc     <= {{WIDTH{1'b0}}, b_in};
    end else if (running) begin
      acc <= product;
      cnt <= cnt + 1'b1;
      if (done)
        running <= 1'b0;
    end
  end

endmodule

// File: rtl/blue_seq_alu.sv
// Sequential ALU: single-cycle ops finish on the accept edge, MUL runs through the
// iterative multiplier; results are held in DONE until the consumer takes them.
module blue_seq_alu
  import blue_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  blue_seq_alu_if.slave   bus
);

  localparam int SHW = $clog2(WIDTH);

  state_e             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2:0]         znc_q;
  op_e                op_dec;
  logic               accept;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   res_a;
  logic [WIDTH-1:0]   res_b;
  logic [2:0]         res_znc;
  logic               carry;
  logic               flag_wr;
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     sh_l;
  logic [WIDTH:0]     sh_r;
  logic [SHW-1:0]     amt;

  function automatic logic [2:0] make_flags(input logic [WIDTH-1:0] r, input logic c);
    logic [2:0] f;
    f        = '0;
    f[Z_BIT] = (r == '0);
    f[N_BIT] = r[WIDTH-1];
    f[C_BIT] = c;
    return f;
  endfunction

  // Opcodes above CMP, including any extra high bits when OPW > 4, decode as NOP
  assign op_dec = (bus.op <= OPW'(OP_CMP)) ? op_e'(bus.op[3:0]) : OP_NOP;

  assign bus.in_ready  = (state == ST_IDLE) && !rst;
  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state == ST_BUSY);
  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.znc_out   = znc_q;
  assign accept        = bus.in_valid && bus.in_ready;
  assign amt           = bus.b_in[SHW-1:0];

  always_comb begin
    res_a   = bus.a_in;
    res_b   = bus.b_in;
    res_znc = znc_q;
    carry   = 1'b0;
    flag_wr = 1'b1;
    sum_w   = {1'b0, bus.a_in} + {1'b0, bus.b_in};
    sh_l    = {1'b0, bus.a_in} << amt;
    sh_r    = {bus.a_in, 1'b0} >> amt;
    case (op_dec)
      OP_ADD: begin
        res_a = sum_w[WIDTH-1:0];
        carry = sum_w[WIDTH];
      end
      OP_SUB: begin
        res_a = bus.a_in - bus.b_in;
        carry = (bus.a_in >= bus.b_in);
      end
      OP_CMP: carry = (bus.a_in >= bus.b_in);
      OP_AND: res_a = bus.a_in & bus.b_in;
      OP_OR:  res_a = bus.a_in | bus.b_in;
      OP_XOR: res_a = bus.a_in ^ bus.b_in;
      OP_NOT: res_a = ~bus.a_in;
      OP_SHL: begin
        res_a = sh_l[WIDTH-1:0];
        carry = sh_l[WIDTH];
      end
      OP_SHR: begin
        res_a = sh_r[WIDTH:1];
        carry = sh_r[0];
      end
      default: flag_wr = 1'b0;
    endcase
    if (flag_wr)
      res_znc = make_flags(res_a, carry);
  end

  blue_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && (op_dec == OP_MUL)),
    .a_in    (bus.a_in),
    .b_in    (bus.b_in),
    .done    (mul_done),
    .product (mul_product)
  );

  // Result registers only change when a transaction completes, so they hold through backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      znc_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          if (op_dec == OP_MUL) begin
            state <= ST_BUSY;
          end else begin
            state <= ST_DONE;
            a_q   <= res_a;
            b_q   <= res_b;
            znc_q <= res_znc;
          end
        end
        ST_BUSY: if (mul_done) begin
          state <= ST_DONE;
          a_q   <= mul_product[WIDTH-1:0];
          b_q   <= mul_product[2*WIDTH-1:WIDTH];
          znc_q <= make_flags(mul_product[WIDTH-1:0], mul_product[2*WIDTH-1:WIDTH] != '0);
        end
        ST_DONE: if (bus.out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blue_seq_alu.sv
// Directed bench for blue_seq_alu at WIDTH=16: each task drives one scenario and checks inline.
module tb_blue_seq_alu;
  import blue_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   passed;
  int   lat;
  int   busy_cycles;

  blue_seq_alu_if #(.WIDTH(16), .OPW(4)) bus ();

  blue_seq_alu #(.WIDTH(16), .OPW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  // Presents one command at a negedge, scrambles operands after the accept edge,
  // then waits (bounded) for out_valid, counting latency and busy cycles.
  task automatic send(input op_e op_v, input logic [15:0] a_v, input logic [15:0] b_v);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = op_v;
    bus.a_in     = a_v;
    bus.b_in     = b_v;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a_in     = ~a_v;
    bus.b_in     = b_v ^ 16'h5A5A;
    bus.op       = OP_XOR;
  endtask

  task automatic wait_done(output int lat_o, output int busy_o);
    lat_o  = 1;
    busy_o = 0;
    while (!bus.out_valid && lat_o < 64) begin
      if (bus.busy) busy_o++;
      @(negedge clk);
      lat_o++;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", bus.busy); else passed++;
    checks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready got %b want 0", bus.in_ready); else passed++;
    checks++; if ({bus.a_out, bus.b_out} !== 32'h0) $display("[TB] FAIL reset_data got %h want 00000000", {bus.a_out, bus.b_out}); else passed++;
    checks++; if (bus.znc_out !== 3'b000) $display("[TB] FAIL reset_znc got %b want 000", bus.znc_out); else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL release_in_ready got %b want 1", bus.in_ready); else passed++;
  endtask

  task automatic test_add();
    send(OP_ADD, 16'hFFFF, 16'h0001);
    wait_done(lat, busy_cycles);
    checks++; if (lat !== 1) $display("[TB] FAIL add_latency got %0d want 1", lat); else passed++;
    checks++; if (bus.a_out !== 16'h0000) $display("[TB] FAIL add_a got %h want 0000", bus.a_out); else passed++;
    checks++; if (bus.b_out !== 16'h0001) $display("[TB] FAIL add_b got %h want 0001", bus.b_out); else passed++;
    checks++; if (bus.znc_out !== 3'b101) $display("[TB] FAIL add_znc got %b want 101", bus.znc_out); else passed++;
    release_result();
  endtask

  task automatic test_sub_cmp();
    send(OP_SUB, 16'h0003, 16'h0005);
    wait_done(lat, busy_cycles);
    checks++; if (bus.a_out !== 16'hFFFE) $display("[TB] FAIL sub_a got %h want fffe", bus.a_out); else passed++;
    checks++; if (bus.znc_out !== 3'b010) $display("[TB] FAIL sub_znc got %b want 010", bus.znc_out); else passed++;
    release_result();
    send(OP_CMP, 16'h0005, 16'h0003);
    wait_done(lat, busy_cycles);
    checks++; if (bus.a_out !== 16'h0005) $display("[TB] FAIL cmp_a got %h want 0005", bus.a_out); else passed++;
    checks++; if (bus.b_out !== 16'h0003) $display("[TB] FAIL cmp_b got %h want 0003", bus.b_out); else passed++;
    checks++; if (bus.znc_out !== 3'b001) $display("[TB] FAIL cmp_znc got %b want 001", bus.znc_out); else passed++;
    release_result();
  endtask

  task automatic test_mul();
    send(OP_MUL, 16'h1234, 16'h0100);
    wait_done(lat, busy_cycles);
    checks++; if (lat !== 17) $display("[TB] FAIL mul_latency got %0d want 17", lat); else passed++;
    checks++; if (busy_cycles !== 16) $display("[TB] FAIL mul_busy_cycles got %0d want 16", busy_cycles); else passed++;
    checks++; if (bus.a_out !== 16'h3400) $display("[TB] FAIL mul_lo got %h want 3400", bus.a_out); else passed++;
    checks++; if (bus.b_out !== 16'h0012) $display("[TB] FAIL mul_hi got %h want 0012", bus.b_out); else passed++;
    checks++; if (bus.znc_out !== 3'b001) $display("[TB] FAIL mul_znc got %b want 001", bus.znc_out); else passed++;
    release_result();
    send(OP_MUL, 16'hFFFF, 16'hFFFF);
    wait_done(lat, busy_cycles);
    checks++; if ({bus.b_out, bus.a_out} !== 32'hFFFE0001) $display("[TB] FAIL mul_max got %h want fffe0001", {bus.b_out, bus.a_out}); else passed++;
    checks++; if (bus.znc_out !== 3'b001) $display("[TB] FAIL mul_max_znc got %b want 001", bus.znc_out); else passed++;
    release_result();
  endtask

  task automatic test_shift();
    send(OP_SHL, 16'h8001, 16'h0001);
    wait_done(lat, busy_cycles);
    checks++; if (bus.a_out !== 16'h0002) $display("[TB] FAIL shl_a got %h want 0002", bus.a_out); else passed++;
    checks++; if (bus.znc_out !== 3'b001) $display("[TB] FAIL shl_znc got %b want 001", bus.znc_out); else passed++;
    release_result();
    send(OP_SHR, 16'h0001, 16'h0000);
    wait_done(lat, busy_cycles);
    checks++; if (bus.a_out !== 16'h0001) $display("[TB] FAIL shr0_a got %h want 0001", bus.a_out); else passed++;
    checks++; if (bus.znc_out !== 3'b000) $display("[TB] FAIL shr0_znc got %b want 000", bus.znc_out); else passed++;
    release_result();
    send(OP_SHR, 16'h00F4, 16'h0003);
    wait_done(lat, busy_cycles);
    checks++; if (bus.a_out !== 16'h001E) $display("[TB] FAIL shr3_a got %h want 001e", bus.a_out); else passed++;
    checks++; if (bus.znc_out !== 3'b001) $display("[TB] FAIL shr3_znc got %b want 001", bus.znc_out); else passed++;
    release_result();
  endtask

  task automatic test_logic_nop();
    send(OP_AND, 16'hFF00, 16'h0FF0);
    wait_done(lat, busy_cycles);
    checks++; if ({bus.a_out, bus.znc_out} !== {16'h0F00, 3'b000}) $display("[TB] FAIL and_res got %h/%b want 0f00/000", bus.a_out, bus.znc_out); else passed++;
    release_result();
    send(OP_OR, 16'h8000, 16'h0001);
    wait_done(lat, busy_cycles);
    checks++; if ({bus.a_out, bus.znc_out} !== {16'h8001, 3'b010}) $display("[TB] FAIL or_res got %h/%b want 8001/010", bus.a_out, bus.znc_out); else passed++;
    release_result();
    send(OP_NOT, 16'hFFFF, 16'h1357);
    wait_done(lat, busy_cycles);
    checks++; if ({bus.a_out, bus.znc_out} !== {16'h0000, 3'b100}) $display("[TB] FAIL not_res got %h/%b want 0000/100", bus.a_out, bus.znc_out); else passed++;
    checks++; if (bus.b_out !== 16'h1357) $display("[TB] FAIL not_b got %h want 1357", bus.b_out); else passed++;
    release_result();
    send(OP_ADD, 16'h8000, 16'h8000);
    wait_done(lat, busy_cycles);
    release_result();
    send(op_e'(4'd12), 16'h8000, 16'h1234);
    wait_done(lat, busy_cycles);
    checks++; if (lat !== 1) $display("[TB] FAIL nop_latency got %0d want 1", lat); else passed++;
    checks++; if ({bus.a_out, bus.b_out} !== 32'h80001234) $display("[TB] FAIL nop_data got %h want 80001234", {bus.a_out, bus.b_out}); else passed++;
    checks++; if (bus.znc_out !== 3'b101) $display("[TB] FAIL nop_znc_kept got %b want 101", bus.znc_out); else passed++;
    release_result();
  endtask

  task automatic test_reset_mid_mul();
    send(OP_MUL, 16'h1234, 16'h0100);
    repeat (7) @(negedge clk);
    checks++; if ({bus.busy, bus.znc_out} !== 4'b1101) $display("[TB] FAIL mid_mul_busy_znc got %b want 1101", {bus.busy, bus.znc_out}); else passed++;
    rst = 1'b1;
    #1;
    checks++; if ({bus.out_valid, bus.busy} !== 2'b00) $display("[TB] FAIL rst_mul_valid_busy got %b want 00", {bus.out_valid, bus.busy}); else passed++;
    checks++; if (bus.znc_out !== 3'b000) $display("[TB] FAIL rst_mul_znc got %b want 000", bus.znc_out); else passed++;
    checks++; if ({bus.a_out, bus.b_out} !== 32'h0) $display("[TB] FAIL rst_mul_data got %h want 00000000", {bus.a_out, bus.b_out}); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL rst_mul_in_ready got %b want 1", bus.in_ready); else passed++;
    repeat (12) @(negedge clk);
    checks++; if ({bus.out_valid, bus.busy, bus.a_out} !== 18'h0) $display("[TB] FAIL rst_mul_no_partial got %h want 00000", {bus.out_valid, bus.busy, bus.a_out}); else passed++;
    send(OP_ADD, 16'h0002, 16'h0003);
    wait_done(lat, busy_cycles);
    checks++; if ({bus.a_out, bus.znc_out} !== {16'h0005, 3'b000}) $display("[TB] FAIL post_rst_add got %h/%b want 0005/000", bus.a_out, bus.znc_out); else passed++;
    release_result();
  endtask

  task automatic test_backpressure();
    int bad;
    send(OP_ADD, 16'h1111, 16'h2222);
    wait_done(lat, busy_cycles);
    checks++; if ({bus.a_out, bus.znc_out} !== {16'h3333, 3'b000}) $display("[TB] FAIL bp_add got %h/%b want 3333/000", bus.a_out, bus.znc_out); else passed++;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2) == 0;
      bus.op       = (i % 2) ? OP_SUB : OP_MUL;
      bus.a_in     = 16'(i * 16'h0F0F);
      bus.b_in     = 16'(16'hABCD + i);
      @(negedge clk);
      bad = 0;
      if ({bus.a_out, bus.b_out} !== 32'h33332222) bad = 1;
      if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b100) bad = 1;
      checks++; if (bad !== 0) $display("[TB] FAIL bp_hold cycle %0d got %h %b%b%b want 33332222 100", i, {bus.a_out, bus.b_out}, bus.out_valid, bus.in_ready, bus.busy); else passed++;
    end
    bus.in_valid = 1'b0;
    release_result();
    checks++; if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) $display("[TB] FAIL bp_after_release got %b want 010", {bus.out_valid, bus.in_ready, bus.busy}); else passed++;
    checks++; if (bus.a_out !== 16'h3333) $display("[TB] FAIL bp_no_second_cmd got %h want 3333", bus.a_out); else passed++;
  endtask

  initial begin
    checks        = 0;
    passed        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub_cmp();
    test_mul();
    test_shift();
    test_logic_nop();
    test_reset_mid_mul();
    test_backpressure();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
